// File: rtl/reg_display_ctrl_if.sv
// Pixel write port between reg_display_ctrl and vga_adapter.
// The controller drives color/x/y/write/busy; the adapter side drives hold.
interface reg_display_ctrl_if;
  logic [8:0] color;
  logic [9:0] x;
  logic [8:0] y;
  logic       write;
  logic       busy;
  logic       hold;

  modport master (
    output color, x, y, write, busy,
    input  hold
  );

  modport slave (
    input  color, x, y, write, busy,
    output hold
  );
endinterface

// File: rtl/reg_display_ctrl.sv
// reg_display_ctrl: keeps the eight 4-bit register glyphs in the VGA
// framebuffer current, sweeping one 5x7 hex glyph per changed register,
// one pixel per cycle. Optional label glyphs: define REG_DISP_LABEL_EN.
module reg_display_ctrl #(
  parameter int unsigned X_ORIGIN    = 114,
  parameter int unsigned Y_ORIGIN    = 50,
  parameter int unsigned SPACING     = 72,
  parameter int unsigned LABEL_DX    = 64,
  parameter logic [8:0]  DATA_COLOR  = 9'b111000000,
  parameter logic [8:0]  LABEL_COLOR = 9'b000111000,
  parameter logic [8:0]  BACK_COLOR  = 9'b000000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [3:0]          R0,
  input  logic [3:0]          R1,
  input  logic [3:0]          R2,
  input  logic [3:0]          R3,
  input  logic [3:0]          R4,
  input  logic [3:0]          R5,
  input  logic [3:0]          R6,
  input  logic [3:0]          R7,
  reg_display_ctrl_if.master  disp
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DRAW     = 2'd1;
`ifdef REG_DISP_LABEL_EN
  localparam logic [1:0] S_DRAW_LBL = 2'd2;
`endif

  logic [1:0]  state;
  logic [3:0]  r_arr [8];
  logic [3:0]  drawn [8];
  logic [7:0]  valid;
  logic [7:0]  need;
  logic [2:0]  sel;
  logic        any_need;
  logic [2:0]  cur_idx;
  logic [3:0]  digit;
  logic [2:0]  px;
  logic [2:0]  py;
  logic [3:0]  glyph;
  logic [31:0] x_base;
  logic [8:0]  on_color;
  logic        lit;
  logic [8:0]  pix_color;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [31:0] x_full;
  logic [31:0] y_full;

  // Segment lit test for local cell position (px,py); patterns are gfedcba.
  function automatic logic seg_lit(input logic [3:0] d, input logic [2:0] cx,
                                   input logic [2:0] cy);
    logic [6:0] s;
    logic       mid_x;
    case (d)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    mid_x = (cx >= 3'd1) && (cx <= 3'd3);
    seg_lit = (s[0] && cy == 3'd0 && mid_x)
           || (s[1] && cx == 3'd4 && cy >= 3'd1 && cy <= 3'd3)
           || (s[2] && cx == 3'd4 && cy >= 3'd4 && cy <= 3'd6)
           || (s[3] && cy == 3'd6 && mid_x)
           || (s[4] && cx == 3'd0 && cy >= 3'd4 && cy <= 3'd6)
           || (s[5] && cx == 3'd0 && cy >= 3'd1 && cy <= 3'd3)
           || (s[6] && cy == 3'd3 && mid_x);
  endfunction

  // Register change detection and fixed-priority (lowest index) selection.
  always_comb begin
    r_arr[0] = R0; r_arr[1] = R1; r_arr[2] = R2; r_arr[3] = R3;
    r_arr[4] = R4; r_arr[5] = R5; r_arr[6] = R6; r_arr[7] = R7;
    need     = '0;
    sel      = '0;
    any_need = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      need[i] = !valid[i] || (r_arr[i] != drawn[i]);
    end
    for (int unsigned i = 0; i < 8; i++) begin
      if (need[i] && !any_need) begin
        sel      = 3'(i);
        any_need = 1'b1;
      end
    end
  end

  // Current pixel address and colour for the glyph being swept.
  always_comb begin
    glyph    = digit;
    on_color = DATA_COLOR;
    x_base   = X_ORIGIN + 32'(cur_idx) * SPACING;
`ifdef REG_DISP_LABEL_EN
    if (state == S_DRAW_LBL) begin
      glyph    = {1'b0, cur_idx};
      on_color = LABEL_COLOR;
      x_base   = X_ORIGIN + 32'(cur_idx) * SPACING - LABEL_DX;
    end
`endif
    lit       = seg_lit(glyph, px, py);
    pix_color = lit ? on_color : BACK_COLOR;
    x_full    = x_base + 32'(px);
    y_full    = Y_ORIGIN + 32'(py);
    pix_x     = x_full[9:0];
    pix_y     = y_full[8:0];
  end

`ifndef REG_DISP_LABEL_EN
  logic unused_label;
  assign unused_label = ^{LABEL_COLOR, LABEL_DX[0]};
`endif

  // Sequencer: select a stale register in IDLE, then emit one pixel per
  // non-held cycle; outputs are registered.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      valid      <= '0;
      for (int unsigned i = 0; i < 8; i++) drawn[i] <= '0;
      cur_idx    <= '0;
      digit      <= '0;
      px         <= '0;
      py         <= '0;
      disp.write <= 1'b0;
      disp.busy  <= 1'b0;
      disp.color <= '0;
      disp.x     <= '0;
      disp.y     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          disp.write <= 1'b0;
          if (!disp.hold && any_need) begin
            cur_idx      <= sel;
            digit        <= r_arr[sel];
            drawn[sel]   <= r_arr[sel];
            valid[sel]   <= 1'b1;
            px           <= '0;
            py           <= '0;
            disp.busy    <= 1'b1;
`ifdef REG_DISP_LABEL_EN
            state        <= S_DRAW_LBL;
`else
            state        <= S_DRAW;
`endif
          end else begin
            disp.busy <= 1'b0;
          end
        end
`ifdef REG_DISP_LABEL_EN
        S_DRAW_LBL,
`endif
        S_DRAW: begin
          disp.busy <= 1'b1;
          if (disp.hold) begin
            disp.write <= 1'b0;
          end else begin
            disp.write <= 1'b1;
            disp.color <= pix_color;
            disp.x     <= pix_x;
            disp.y     <= pix_y;
            if (px == 3'd4) begin
              px <= '0;
              if (py == 3'd6) begin
                py <= '0;
`ifdef REG_DISP_LABEL_EN
                state <= (state == S_DRAW_LBL) ? S_DRAW : S_IDLE;
`else
                state <= S_IDLE;
`endif
              end else begin
                py <= py + 3'd1;
              end
            end else begin
              px <= px + 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
